chunk_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream DMA command port among N chunk-address-looper command streams in the read pipeline. Each requester emits bursts of commands terminated by `islast`. Once a requester wins, the arbiter locks onto it until its `islast` command is accepted, so a burst is never interleaved with other requesters. The selected command is registered and tagged with the requester index for response routing.

---
 rtl/chunk_cmd_arbiter_if.sv | 38 +++
 rtl/chunk_cmd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_chunk_cmd_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_cmd_arbiter_if.sv
// Command bus between N chunk-address-looper requesters and the shared DMA command port.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface chunk_cmd_arbiter_if #(
  parameter int N     = 2,
  parameter int GBW   = 32,
  parameter int C_BW  = 6,
  parameter int V_BW1 = 5,
  parameter int IDBW  = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]            src_rdy;
  logic [N-1:0]            src_ack;
  logic [N-1:0][1:0]       i_cmd_type;
  logic [N-1:0]            i_cmd_islast;
  logic [N-1:0][GBW-1:0]   i_cmd_addr;
  logic [N-1:0][C_BW-1:0]  i_cmd_addrofs;
  logic [N-1:0][V_BW1-1:0] i_cmd_len;

  logic                    dst_rdy;
  logic                    dst_ack;
  logic [1:0]              o_cmd_type;
  logic                    o_cmd_islast;
  logic [GBW-1:0]          o_cmd_addr;
  logic [C_BW-1:0]         o_cmd_addrofs;
  logic [V_BW1-1:0]        o_cmd_len;
  logic [IDBW-1:0]         o_cmd_id;

  modport master (
    output src_rdy, i_cmd_type, i_cmd_islast, i_cmd_addr, i_cmd_addrofs, i_cmd_len, dst_ack,
    input  src_ack, dst_rdy, o_cmd_type, o_cmd_islast, o_cmd_addr, o_cmd_addrofs, o_cmd_len,
           o_cmd_id
  );

  modport slave (
    input  src_rdy, i_cmd_type, i_cmd_islast, i_cmd_addr, i_cmd_addrofs, i_cmd_len, dst_ack,
    output src_ack, dst_rdy, o_cmd_type, o_cmd_islast, o_cmd_addr, o_cmd_addrofs, o_cmd_len,
           o_cmd_id
  );
endinterface

// File: rtl/chunk_cmd_arbiter.sv
// Round-robin arbiter with burst locking onto one registered DMA command port.
// The CHUNK_CMD_ARB_STAT_EN macro adds per-requester grant and stall counters.
module chunk_cmd_arbiter #(
  parameter int N     = 2,
  parameter int GBW   = 32,
  parameter int C_BW  = 6,
  parameter int V_BW1 = 5,
  parameter int IDBW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
`ifdef CHUNK_CMD_ARB_STAT_EN
  input  logic                 i_stat_clr,
  output logic [N-1:0][15:0]   o_stat_cmds,
  output logic [N-1:0][15:0]   o_stat_stall,
`endif
  chunk_cmd_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDBW-1:0]  ptr_q, ptr_d;
  logic [IDBW-1:0]  owner_q, owner_d;
  logic             dst_rdy_q, dst_rdy_d;
  logic [1:0]       type_q, type_d;
  logic             islast_q, islast_d;
  logic [GBW-1:0]   addr_q, addr_d;
  logic [C_BW-1:0]  addrofs_q, addrofs_d;
  logic [V_BW1-1:0] len_q, len_d;
  logic [IDBW-1:0]  id_q, id_d;

  logic             free_s;
  logic             found_s;
  logic             grant_s;
  logic             hit_s;
  logic [IDBW-1:0]  win_s;
  logic [IDBW-1:0]  win_next_s;
  logic [N-1:0]     ack_s;
  int               scan_idx_s;

  // Winner selection: the lock owner only, or the first ready requester from ptr.
  // The scan runs from the farthest offset down so that the nearest ready requester wins.
  always_comb begin
    free_s     = !dst_rdy_q || bus.dst_ack;
    win_s      = '0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    scan_idx_s = 0;
    case (state_q)
      ST_LOCKED: begin
        win_s   = owner_q;
        found_s = bus.src_rdy[owner_q];
      end
      default: begin
        for (int k = N - 1; k >= 0; k--) begin
          scan_idx_s = (int'(ptr_q) + k >= N) ? int'(ptr_q) + k - N : int'(ptr_q) + k;
          hit_s      = bus.src_rdy[IDBW'(scan_idx_s)];
          win_s      = hit_s ? IDBW'(scan_idx_s) : win_s;
          found_s    = found_s | hit_s;
        end
      end
    endcase
    grant_s    = found_s && free_s && !i_rst;
    win_next_s = (win_s == IDBW'(N - 1)) ? '0 : win_s + IDBW'(1);
    for (int i = 0; i < N; i++) begin
      ack_s[i] = grant_s && (win_s == IDBW'(i));
    end
  end

  // Next state: load the output register on a grant and update the lock and the pointer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    dst_rdy_d = dst_rdy_q;
    type_d    = type_q;
    islast_d  = islast_q;
    addr_d    = addr_q;
    addrofs_d = addrofs_q;
    len_d     = len_q;
    id_d      = id_q;
    if (grant_s) begin
      dst_rdy_d = 1'b1;
      type_d    = bus.i_cmd_type[win_s];
      islast_d  = bus.i_cmd_islast[win_s];
      addr_d    = bus.i_cmd_addr[win_s];
      addrofs_d = bus.i_cmd_addrofs[win_s];
      len_d     = bus.i_cmd_len[win_s];
      id_d      = win_s;
      if (bus.i_cmd_islast[win_s]) begin
        state_d = ST_UNLOCKED;
        ptr_d   = win_next_s;
      end else begin
        state_d = ST_LOCKED;
        owner_d = win_s;
      end
    end else if (bus.dst_ack) begin
      dst_rdy_d = 1'b0;
    end else begin
      dst_rdy_d = dst_rdy_q;
    end
  end

  // State and output command register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_UNLOCKED;
      ptr_q     <= '0;
      owner_q   <= '0;
      dst_rdy_q <= 1'b0;
      type_q    <= 2'd0;
      islast_q  <= 1'b0;
      addr_q    <= '0;
      addrofs_q <= '0;
      len_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      dst_rdy_q <= dst_rdy_d;
      type_q    <= type_d;
      islast_q  <= islast_d;
      addr_q    <= addr_d;
      addrofs_q <= addrofs_d;
      len_q     <= len_d;
      id_q      <= id_d;
    end
  end

  assign bus.src_ack       = ack_s;
  assign bus.dst_rdy       = dst_rdy_q;
  assign bus.o_cmd_type    = type_q;
  assign bus.o_cmd_islast  = islast_q;
  assign bus.o_cmd_addr    = addr_q;
  assign bus.o_cmd_addrofs = addrofs_q;
  assign bus.o_cmd_len     = len_q;
  assign bus.o_cmd_id      = id_q;

`ifdef CHUNK_CMD_ARB_STAT_EN
  logic [N-1:0][15:0] stat_cmds_q;
  logic [N-1:0][15:0] stat_stall_q;

  // Saturating grant and stall counters. A clear takes priority over the increments.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stat_clr) begin
      stat_cmds_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ack_s[i] && (stat_cmds_q[i] != 16'hFFFF)) begin
          stat_cmds_q[i] <= stat_cmds_q[i] + 16'd1;
        end
        if (bus.src_rdy[i] && !ack_s[i] && (stat_stall_q[i] != 16'hFFFF)) begin
          stat_stall_q[i] <= stat_stall_q[i] + 16'd1;
        end
      end
    end
  end

  assign o_stat_cmds  = stat_cmds_q;
  assign o_stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_chunk_cmd_arbiter.sv
// Self-checking bench for chunk_cmd_arbiter: directed scenarios followed by random bursts.
// Each cycle is checked against a queue-based behavioural model of the arbitration rules.
module tb_chunk_cmd_arbiter;
  localparam int N     = 2;
  localparam int GBW   = 32;
  localparam int C_BW  = 6;
  localparam int V_BW1 = 5;
  localparam int IDBW  = 1;

  typedef struct packed {
    logic [1:0]       typ;
    logic             last;
    logic [GBW-1:0]   addr;
    logic [C_BW-1:0]  ofs;
    logic [V_BW1-1:0] len;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clr_v = 1'b0;

  chunk_cmd_arbiter_if #(.N(N), .GBW(GBW), .C_BW(C_BW), .V_BW1(V_BW1), .IDBW(IDBW)) bus();

`ifdef CHUNK_CMD_ARB_STAT_EN
  logic               stat_clr;
  logic [N-1:0][15:0] stat_cmds;
  logic [N-1:0][15:0] stat_stall;
`endif

  chunk_cmd_arbiter #(.N(N), .GBW(GBW), .C_BW(C_BW), .V_BW1(V_BW1), .IDBW(IDBW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
`ifdef CHUNK_CMD_ARB_STAT_EN
    .i_stat_clr   (stat_clr),
    .o_stat_cmds  (stat_cmds),
    .o_stat_stall (stat_stall),
`endif
    .bus          (bus)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  cmd_t srcq [N][$];
  bit   pres [N];
  int   rdy_pct = 100;

  bit   m_locked;
  int   m_owner;
  int   m_ptr;
  bit   m_vld;
  cmd_t m_out;
  int   m_id;
  int   m_cmds  [N];
  int   m_stall [N];

  int             dlog_id[$];
  logic [GBW-1:0] dlog_addr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [GBW-1:0] a, input logic l);
    cmd_t c;
    c.typ  = 2'($urandom_range(0, 3));
    c.last = l;
    c.addr = a;
    c.ofs  = C_BW'($urandom);
    c.len  = V_BW1'($urandom_range(0, 16));
    return c;
  endfunction

  // One clock cycle: drive at negedge, check src_ack mid-cycle, check registers after posedge.
  task automatic step(input int ack_mode, input bit rst_v);
    logic [N-1:0] rdy;
    logic [N-1:0] exp_ack;
    bit           dack;
    int           win;
    cmd_t         h;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < rdy_pct) pres[i] = 1'b1;
      rdy[i] = pres[i];
      h = pres[i] ? srcq[i][0] : cmd_t'({$urandom, $urandom});
      bus.i_cmd_type[i]    = h.typ;
      bus.i_cmd_islast[i]  = h.last;
      bus.i_cmd_addr[i]    = h.addr;
      bus.i_cmd_addrofs[i] = h.ofs;
      bus.i_cmd_len[i]     = h.len;
    end
    dack = m_vld && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 3) != 0));
    rst         = rst_v;
    bus.src_rdy = rdy;
    bus.dst_ack = dack;
`ifdef CHUNK_CMD_ARB_STAT_EN
    stat_clr = clr_v;
`endif
    win = -1;
    if (!rst_v && (!m_vld || dack)) begin
      if (m_locked) begin
        if (((rdy >> m_owner) & 1) != 0) win = m_owner;
      end else begin
        for (int k = 0; k < N && win < 0; k++) begin
          if (((rdy >> ((m_ptr + k) % N)) & 1) != 0) win = (m_ptr + k) % N;
        end
      end
    end
    exp_ack = '0;
    if (win >= 0) exp_ack = N'(1) << win;
    #2;
    chk("src_ack", 64'(bus.src_ack), 64'(exp_ack));
    if (bus.dst_rdy && dack) begin
      dlog_id.push_back(int'(bus.o_cmd_id));
      dlog_addr.push_back(bus.o_cmd_addr);
    end
    @(posedge clk);
    if (rst_v || clr_v) begin
      for (int i = 0; i < N; i++) begin
        m_cmds[i]  = 0;
        m_stall[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (win == i) m_cmds[i] = (m_cmds[i] < 65535) ? m_cmds[i] + 1 : 65535;
        else if (rdy[i]) m_stall[i] = (m_stall[i] < 65535) ? m_stall[i] + 1 : 65535;
      end
    end
    if (rst_v) begin
      m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_vld = 1'b0; m_out = '0; m_id = 0;
    end else if (win >= 0) begin
      m_out = srcq[win].pop_front();
      pres[win] = 1'b0;
      m_id  = win;
      m_vld = 1'b1;
      if (m_out.last) begin
        m_locked = 1'b0;
        m_ptr    = (win + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_owner  = win;
      end
    end else if (dack) begin
      m_vld = 1'b0;
    end
    #1;
    chk("dst_rdy", 64'(bus.dst_rdy), 64'(m_vld));
    chk("o_type", 64'(bus.o_cmd_type), 64'(m_out.typ));
    chk("o_islast", 64'(bus.o_cmd_islast), 64'(m_out.last));
    chk("o_addr", 64'(bus.o_cmd_addr), 64'(m_out.addr));
    chk("o_addrofs", 64'(bus.o_cmd_addrofs), 64'(m_out.ofs));
    chk("o_len", 64'(bus.o_cmd_len), 64'(m_out.len));
    chk("o_id", 64'(bus.o_cmd_id), 64'(m_id));
`ifdef CHUNK_CMD_ARB_STAT_EN
    for (int i = 0; i < N; i++) begin
      chk($sformatf("stat_cmds%0d", i), 64'(stat_cmds[i]), 64'(m_cmds[i]));
      chk($sformatf("stat_stall%0d", i), 64'(stat_stall[i]), 64'(m_stall[i]));
    end
`endif
  endtask

  task automatic check_log(input string tag, input int n, input int ids[8],
                           input logic [GBW-1:0] ads[8]);
    chk({tag, "_count"}, 64'(dlog_id.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_id%0d", tag, k), 64'((k < dlog_id.size()) ? dlog_id[k] : -1),
          64'(ids[k]));
      chk($sformatf("%s_addr%0d", tag, k),
          64'((k < dlog_addr.size()) ? dlog_addr[k] : {GBW{1'b1}}), 64'(ads[k]));
    end
  endtask

  initial begin
    bit busy;
    bus.src_rdy       = '0;
    bus.dst_ack       = 1'b0;
    bus.i_cmd_type    = '0;
    bus.i_cmd_islast  = '0;
    bus.i_cmd_addr    = '0;
    bus.i_cmd_addrofs = '0;
    bus.i_cmd_len     = '0;
`ifdef CHUNK_CMD_ARB_STAT_EN
    stat_clr = 1'b0;
`endif
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_vld = 1'b0; m_out = '0; m_id = 0;
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0; m_cmds[i] = 0; m_stall[i] = 0;
    end

    // Reset held for two cycles with both requesters ready, then streaming.
    srcq[0].push_back(mk(32'h100, 1'b0));
    srcq[0].push_back(mk(32'h140, 1'b0));
    srcq[0].push_back(mk(32'h180, 1'b1));
    srcq[1].push_back(mk(32'h200, 1'b1));
    step(1, 1'b1);
    step(1, 1'b1);
    chk("rst_dst_rdy", 64'(bus.dst_rdy), 64'd0);
    chk("rst_addr", 64'(bus.o_cmd_addr), 64'd0);
    dlog_id.delete(); dlog_addr.delete();
    repeat (6) step(1, 1'b0);
    check_log("stream", 4, '{0, 0, 0, 1, 0, 0, 0, 0},
              '{32'h100, 32'h140, 32'h180, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0});

    // Single-command bursts from both requesters alternate.
    for (int k = 0; k < 3; k++) begin
      srcq[0].push_back(mk(32'h300 + 32'(k * 16), 1'b1));
      srcq[1].push_back(mk(32'h400 + 32'(k * 16), 1'b1));
    end
    dlog_id.delete(); dlog_addr.delete();
    repeat (8) step(1, 1'b0);
    check_log("fair", 6, '{0, 1, 0, 1, 0, 1, 0, 0},
              '{32'h300, 32'h400, 32'h310, 32'h410, 32'h320, 32'h420, 32'h0, 32'h0});

    // Backpressure: the registered command holds while dst_ack stays low.
    srcq[0].push_back(mk(32'h500, 1'b1));
    srcq[0].push_back(mk(32'h510, 1'b1));
    step(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b0);
      chk("bp_hold_addr", 64'(bus.o_cmd_addr), 64'h500);
      chk("bp_hold_rdy", 64'(bus.dst_rdy), 64'd1);
    end
    step(1, 1'b0);
    chk("bp_release_addr", 64'(bus.o_cmd_addr), 64'h510);

    // Reset in the middle of requester 1's burst.
    srcq[1].push_back(mk(32'h600, 1'b0));
    srcq[1].push_back(mk(32'h640, 1'b1));
    step(1, 1'b0);
    chk("mid_owner_id", 64'(bus.o_cmd_id), 64'd1);
    srcq[0].push_back(mk(32'h700, 1'b1));
    step(1, 1'b1);
    step(1, 1'b0);
    chk("post_rst_id", 64'(bus.o_cmd_id), 64'd0);
    chk("post_rst_addr", 64'(bus.o_cmd_addr), 64'h700);
    repeat (4) step(1, 1'b0);

    // Random bursts with random gaps, backpressure, clears and occasional resets.
    rdy_pct = 70;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) srcq[i].push_back(mk($urandom, 1'(b == len - 1)));
        end
      end
      clr_v = ($urandom_range(0, 99) == 0);
      step(2, ($urandom_range(0, 199) == 0));
      clr_v = 1'b0;
    end

    // Drain with every requester presenting immediately.
    rdy_pct = 100;
    busy = 1'b1;
    for (int c = 0; c < 300 && busy; c++) begin
      step(1, 1'b0);
      busy = m_vld;
      for (int i = 0; i < N; i++) busy = busy || (srcq[i].size() != 0);
    end
    chk("drain_done", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
